// File: rtl/instr_mem_fetch_pkg.sv
// Shared definitions for the fetch-stage instruction memory and the decode stage.
package instr_mem_fetch_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Default NOP encoding, also used by decode for bubbles.
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Synchronous RAM, one write port and one read port; a same-address
// read and write in one cycle returns the old word.
module instr_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem_fetch.sv
// Fetch-stage instruction memory: NOP clear sweep after reset, valid/ready
// fetch with 1-cycle latency, runtime program load, error flagging.
module instr_mem_fetch
    import instr_mem_fetch_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT),
    localparam int               IDX_W    = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              init_done
);

    // Address bits that may be set for an in-range, word-aligned fetch window.
    localparam logic [ADDR_W-1:0] RANGE_MASK = ADDR_W'((64'd1 << (IDX_W + 2)) - 64'd1);

    state_e             state;
    logic [IDX_W-1:0]   cnt;
    logic               accept;
    logic               misaligned;
    logic               out_of_range;
    logic               addr_err;
    logic               rsp_hit;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    assign init_done    = (state == RUN);
    assign req_ready    = init_done && (!rsp_valid || rsp_ready);
    assign accept       = req_valid && req_ready;
    assign misaligned   = |req_addr[1:0];
    assign out_of_range = |(req_addr & ~RANGE_MASK);
    assign addr_err     = misaligned || out_of_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == IDX_W'(DEPTH - 1)) state <= RUN;
        end
    end

    // Sweep owns the write port during INIT; loads arriving then are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = NOP_WORD;
        end else if (ld_en) begin
            mem_we = 1'b1;
        end
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (accept && !addr_err),
        .raddr (req_addr[2 +: IDX_W]),
        .rdata (mem_rdata)
    );

    // RAM output only changes on a good accept, so it stays stable under
    // backpressure; rsp_hit selects between it and the NOP for errors/reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_hit   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= addr_err;
            rsp_hit   <= !addr_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_instr = rsp_hit ? mem_rdata : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed vector table, reset/sweep sequences and random traffic against a
// transaction-level model of the fetch memory.
module tb_instr_mem_fetch;

    localparam int          DEPTH = 1024;
    localparam int          IDX_W = 10;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        ld_en;
    logic [IDX_W-1:0] ld_addr;
    logic [31:0] ld_data;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    instr_mem_fetch #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array plus the one outstanding response.
    logic [31:0] m_mem [DEPTH];
    logic        m_vld;
    logic [31:0] m_instr;
    logic        m_err;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        rr;
        logic        le;
        logic [IDX_W-1:0] la;
        logic [31:0] ld;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_instr;
        logic        e_err;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        m_vld   = 1'b0;
        m_instr = NOP;
        m_err   = 1'b0;
    endtask

    // One RUN-state cycle: drive, check ready, advance model, clock, check response.
    task automatic cycle(input logic v, input logic [31:0] a, input logic rr,
                         input logic le, input logic [IDX_W-1:0] la, input logic [31:0] ld);
        logic exp_rdy;
        logic bad;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        ld_en     = le;
        ld_addr   = la;
        ld_data   = ld;
        #1;
        exp_rdy = !m_vld || rr;
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
        if (v && exp_rdy) begin
            bad     = (a % 4 != 0) || (a >= DEPTH * 4);
            m_vld   = 1'b1;
            m_err   = bad;
            m_instr = bad ? NOP : m_mem[a / 4];
        end else if (rr) begin
            m_vld = 1'b0;
        end
        if (le) m_mem[la] = ld;
        @(posedge clk);
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_vld});
        if (m_vld) begin
            chk("rsp_instr", rsp_instr, m_instr);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        end
    endtask

    task automatic wait_init();
        int  n;
        logic early;
        n     = 0;
        early = 1'b0;
        while (!init_done && n < DEPTH + 16) begin
            if (req_ready) early = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_cycles", n, DEPTH);
        chk("ready_in_init", {31'd0, early}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        model_clear();

        //                v  addr        rr le la  ld            rdy vld instr         err
        tbl[0]  = '{1'b1, 32'd0,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 32'd4,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
        tbl[2]  = '{1'b1, 32'd4092,  1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
        tbl[3]  = '{1'b0, 32'd0,     1'b1, 1'b1, 10'd1, 32'h80010829,  1'b1, 1'b0, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 32'd0,     1'b1, 1'b1, 10'd2, 32'h80020109,  1'b1, 1'b0, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 32'd4,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h80010829,  1'b0};
        tbl[6]  = '{1'b1, 32'd8,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h80020109,  1'b0};
        tbl[7]  = '{1'b1, 32'd4,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h80010829,  1'b0};
        tbl[8]  = '{1'b1, 32'd8,     1'b0, 1'b0, 10'd0, 32'h0,         1'b0, 1'b1, 32'h80010829,  1'b0};
        tbl[9]  = '{1'b1, 32'd8,     1'b0, 1'b0, 10'd0, 32'h0,         1'b0, 1'b1, 32'h80010829,  1'b0};
        tbl[10] = '{1'b1, 32'd8,     1'b0, 1'b0, 10'd0, 32'h0,         1'b0, 1'b1, 32'h80010829,  1'b0};
        tbl[11] = '{1'b1, 32'd8,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h80020109,  1'b0};
        tbl[12] = '{1'b0, 32'd0,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
        tbl[13] = '{1'b1, 32'd6,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, NOP,           1'b1};
        tbl[14] = '{1'b1, 32'd4096,  1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, NOP,           1'b1};
        tbl[15] = '{1'b1, 32'd4092,  1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
        tbl[16] = '{1'b1, 32'd36,    1'b1, 1'b1, 10'd9, 32'hFC220000,  1'b1, 1'b1, 32'h0,         1'b0};
        tbl[17] = '{1'b1, 32'd36,    1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'hFC220000,  1'b0};
        tbl[18] = '{1'b1, 32'd4,     1'b1, 1'b0, 10'd0, 32'h0,         1'b1, 1'b1, 32'h80010829,  1'b0};

        // Reset state
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, NOP);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init();

        // Directed table
        for (int i = 0; i < 19; i++) begin
            req_valid = tbl[i].v;
            rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("tbl%0d_ready", i), {31'd0, req_ready}, {31'd0, tbl[i].e_rdy});
            cycle(tbl[i].v, tbl[i].a, tbl[i].rr, tbl[i].le, tbl[i].la, tbl[i].ld);
            chk($sformatf("tbl%0d_valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_instr", i), rsp_instr, tbl[i].e_instr);
                chk($sformatf("tbl%0d_err", i), {31'd0, rsp_err}, {31'd0, tbl[i].e_err});
            end
        end

        // Mid-run reset with a response pending; loads during the sweep are dropped
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_rsp_instr", rsp_instr, NOP);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ld_en   = 1'b1;
        ld_addr = 10'd1;
        ld_data = 32'hDEADBEEF;
        wait_init();
        ld_en = 1'b0;
        model_clear();
        cycle(1'b1, 32'd4, 1'b1, 1'b0, 10'd0, 32'h0);
        chk("midrst_idx1_cleared", rsp_instr, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = {$urandom_range(0, 31), 2'b00};
            else if (sel == 7) a = {$urandom_range(0, 31), 2'b00} | 32'($urandom_range(1, 3));
            else if (sel == 8) a = $urandom | 32'h0000_1000;
            else               a = 32'd4092;
            cycle(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), 10'($urandom_range(0, 31)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised, synchronous instruction memory for the pipelined core's fetch stage, replacing the fixed combinational ROM lookup.
- Byte-addressed, word-aligned fetch port with valid/ready handshake and 1-cycle read latency.
- Runtime program-load port.
- Post-reset clear sweep that fills every word with NOP before fetch is accepted.
- Flags misaligned and out-of-range fetches instead of aliasing them.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, fetch address width (byte address)
DEPTH, 1024, number of instruction words; power of two, >= 2
NOP_WORD, 0, value written by the clear sweep and returned on error responses

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when req_valid && req_ready
req_addr  in  ADDR_W  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_instr  out  DATA_W  fetched instruction
rsp_err  out  1  response is for a misaligned or out-of-range address
ld_en  in  1  program-load write strobe
ld_addr  in  IDX_W  program-load word index, IDX_W = clog2(DEPTH)
ld_data  in  DATA_W  program-load word
init_done  out  1  clear sweep complete; high in RUN

Behaviour:
- Reset values (asynchronous, while rst high):
  - state = INIT, sweep counter = 0
  - rsp_valid = 0, rsp_instr = NOP_WORD, rsp_err = 0
  - init_done = 0, req_ready = 0
  - Memory contents are not reset asynchronously; they are cleared by the sweep.
- FSM states:
  - INIT: each cycle writes NOP_WORD to mem[cnt] and increments cnt. On the cycle cnt == DEPTH-1 is written, go to RUN. INIT lasts exactly DEPTH cycles after rst deasserts.
  - RUN: terminal state; only rst leaves it.
- In INIT:
  - req_ready = 0.
  - ld_en is ignored; the write is dropped, not queued.
- In RUN, handshake:
  - req_ready = !rsp_valid || rsp_ready (single-entry output register, full throughput).
  - On accept, the response appears the next cycle with rsp_valid = 1.
  - Back-to-back accepts give one response per cycle.
  - While rsp_valid && !rsp_ready, rsp_instr and rsp_err hold stable and no new request is accepted.
  - rsp_valid clears on rsp_ready when no new request is accepted in the same cycle.
- Address decode:
  - idx = req_addr[2 +: IDX_W].
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: any bit of req_addr above bit IDX_W+1 is set.
  - Either condition gives rsp_err = 1, rsp_instr = NOP_WORD, and no memory read.
  - Otherwise rsp_err = 0 and rsp_instr = mem[idx].
- Load port:
  - In RUN, ld_en writes ld_data to mem[ld_addr] at the clock edge.
  - Load and fetch of the same index in the same cycle is read-first: the response carries the old word, and the next fetch sees the new one.
  - Load is independent of the fetch handshake and never stalls.
- rst asserted mid-operation: any pending response is discarded (rsp_valid drops immediately) and the sweep restarts from index 0.

Decomposition:
- Shared package: IDX_W derivation, FSM state enum {INIT, RUN}, and the default NOP encoding, shared with the decode stage.
- One sub-module: instr_mem_array. Single-port-write / single-port-read synchronous RAM with read-first semantics, parametrised by DATA_W and DEPTH.
  - The top multiplexes the write port between the sweep and the load port.
  - The top owns the FSM, handshake and error decode.

Test Plan:
- Reset then idle: init_done rises exactly DEPTH cycles after rst falls; req_ready = 0 before that. Fetching addresses 0, 4 and 4092 after init returns 0x00000000 with rsp_err = 0.
- Load then fetch:
  - Load idx1 = 0x80010829 and idx2 = 0x80020109.
  - Back-to-back fetches of 4 and 8 with rsp_ready = 1 give responses 0x80010829 and 0x80020109 on consecutive cycles, 1 cycle after each accept.
- Backpressure: hold rsp_ready = 0 for 3 cycles with rsp_valid = 1. rsp_instr stays stable and req_ready = 0. On release, the next queued request is accepted in the same cycle.
- Errors:
  - Address 0x6 gives rsp_err = 1, rsp_instr = NOP_WORD.
  - Address 4096 with DEPTH 1024 gives rsp_err = 1.
  - Address 4092 gives rsp_err = 0.
- Collision: ld_en to idx 9 with 0xFC220000 in the same cycle as a fetch of 36 returns the old word; the following fetch of 36 returns 0xFC220000.
- Mid-run reset: assert rst while rsp_valid = 1. rsp_valid goes to 0 asynchronously, init_done = 0, and after the sweep a previously loaded idx1 reads 0.
